// File: rtl/acc_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : acc_sched_if
//  Description : Sample stream bundle for the accumulator sequencer.
//                Input side  : sync_in, din, din_valid (from frame source)
//                Output side : dout, dout_valid, acc_done, acc_first,
//                              chan_idx (towards the accumulator)
//                master = frame source / observer, slave = acc_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
interface acc_sched_if #(
    parameter int DIN_WIDTH  = 16,
    parameter int CHAN_WIDTH = 6
) ();
    logic                        sync_in;
    logic signed [DIN_WIDTH-1:0] din;
    logic                        din_valid;
    logic signed [DIN_WIDTH-1:0] dout;
    logic                        dout_valid;
    logic                        acc_done;
    logic                        acc_first;
    logic [CHAN_WIDTH-1:0]       chan_idx;

    modport master (
        output sync_in, din, din_valid,
        input  dout, dout_valid, acc_done, acc_first, chan_idx
    );

    modport slave (
        input  sync_in, din, din_valid,
        output dout, dout_valid, acc_done, acc_first, chan_idx
    );
endinterface
`default_nettype wire

// File: rtl/acc_sched.sv
`default_nettype none
// ============================================================================
//  Module      : acc_sched
//  Description : Sequencing controller for a signed streaming accumulator.
//                Aligns to the frame sync, counts channels/frames and emits
//                the accumulation-restart strobe (acc_done) on every sample
//                of the first frame of each integration. Data is forwarded
//                with one cycle of latency, matching all control outputs.
//  Ports       : clk, rst_n (async, active low)
//                en        - level enable, low forces IDLE
//                arm       - start integrating at the next sync
//                acc_len   - frames per integration (0 behaves as 1)
//                bus       - stream bundle (acc_sched_if.slave)
//                acc_count - completed integrations since arm
//                frame_err - sticky sync misalignment flag, cleared by arm
//                busy      - controller not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module acc_sched #(
    parameter int DIN_WIDTH  = 16,
    parameter int VEC_LEN    = 64,
    parameter int CHAN_WIDTH = 6,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 arm,
    input  logic [LEN_WIDTH-1:0] acc_len,
    acc_sched_if.slave           bus,
    output logic [CNT_WIDTH-1:0] acc_count,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [CHAN_WIDTH-1:0] CHAN_LAST = CHAN_WIDTH'(VEC_LEN - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_SYNC = 2'd1,
        RUN       = 2'd2
    } state_t;

    state_t                        state;
    logic [CHAN_WIDTH-1:0]         chan;        // channel of the next valid sample
    logic [LEN_WIDTH-1:0]          frame;       // frame of the next valid sample
    logic [LEN_WIDTH-1:0]          len_r;       // frames in the current integration
    logic                          first_int;   // inside the first integration

    logic signed [DIN_WIDTH-1:0]   dout_r;
    logic                          dout_valid_r;
    logic                          acc_done_r;
    logic                          acc_first_r;
    logic [CHAN_WIDTH-1:0]         chan_idx_r;

    // Sample-position bookkeeping for the sample currently at the input.
    logic [LEN_WIDTH-1:0]  len_in;
    logic                  take;
    logic                  resync;
    logic                  restart;
    logic [CHAN_WIDTH-1:0] cur_chan;
    logic [LEN_WIDTH-1:0]  cur_frame;
    logic [LEN_WIDTH-1:0]  cur_len;
    logic                  cur_first;
    logic                  wrap;
    logic                  int_end;

    always_comb begin
        len_in    = (acc_len == '0) ? LEN_WIDTH'(1) : acc_len;
        take      = bus.din_valid &&
                    ((state == RUN) || ((state == WAIT_SYNC) && bus.sync_in));
        // Sync landing mid-frame while running: realign to this sample.
        resync    = (state == RUN) && bus.sync_in && (chan != '0);
        restart   = (state == WAIT_SYNC) || resync;
        cur_chan  = restart ? '0 : chan;
        cur_frame = restart ? '0 : frame;
        // A resync reloads the length from acc_len; a fresh start uses the
        // value latched when armed.
        cur_len   = resync ? len_in : len_r;
        cur_first = restart ? 1'b1 : first_int;
        wrap      = (cur_chan == CHAN_LAST);
        int_end   = wrap && (cur_frame == cur_len - LEN_WIDTH'(1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            chan         <= '0;
            frame        <= '0;
            len_r        <= '0;
            first_int    <= 1'b0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            acc_done_r   <= 1'b0;
            acc_first_r  <= 1'b0;
            chan_idx_r   <= '0;
            acc_count    <= '0;
            frame_err    <= 1'b0;
        end else begin
            dout_r       <= bus.din;
            dout_valid_r <= 1'b0;
            acc_done_r   <= 1'b0;
            acc_first_r  <= 1'b0;

            if (!en) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: begin
                        if (arm) begin
                            state     <= WAIT_SYNC;
                            frame_err <= 1'b0;
                            acc_count <= '0;
                            len_r     <= len_in;
                        end
                    end
                    WAIT_SYNC, RUN: begin
                        if (take) begin
                            state        <= RUN;
                            dout_valid_r <= 1'b1;
                            chan_idx_r   <= cur_chan;
                            acc_done_r   <= (cur_frame == '0);
                            acc_first_r  <= (cur_frame == '0) && cur_first;
                            if (resync) begin
                                frame_err <= 1'b1;
                            end
                            // Start of a follow-on integration completes one.
                            if ((cur_chan == '0) && (cur_frame == '0) && !cur_first) begin
                                acc_count <= acc_count + CNT_WIDTH'(1);
                            end
                            if (int_end) begin
                                chan      <= '0;
                                frame     <= '0;
                                len_r     <= len_in;
                                first_int <= 1'b0;
                            end else if (wrap) begin
                                chan      <= '0;
                                frame     <= cur_frame + LEN_WIDTH'(1);
                                len_r     <= cur_len;
                                first_int <= cur_first;
                            end else begin
                                chan      <= cur_chan + CHAN_WIDTH'(1);
                                frame     <= cur_frame;
                                len_r     <= cur_len;
                                first_int <= cur_first;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.acc_done   = acc_done_r;
    assign bus.acc_first  = acc_first_r;
    assign bus.chan_idx   = chan_idx_r;
    assign busy           = (state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_acc_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_acc_sched
//  Description : Self-checking bench for acc_sched (VEC_LEN = 4). A sample-
//                position reference model predicts every output each cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_acc_sched;

    localparam int VL = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        arm = 1'b0;
    logic [15:0] acc_len = '0;
    logic [31:0] acc_count;
    logic        frame_err;
    logic        busy;

    acc_sched_if #(.DIN_WIDTH(16), .CHAN_WIDTH(2)) bus ();

    acc_sched #(
        .DIN_WIDTH (16),
        .VEC_LEN   (VL),
        .CHAN_WIDTH(2),
        .LEN_WIDTH (16),
        .CNT_WIDTH (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .arm      (arm),
        .acc_len  (acc_len),
        .bus      (bus),
        .acc_count(acc_count),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: position of the next sample within the integration,
    // counted in samples (0 .. VL*frames-1).
    int          m_mode;      // 0 idle, 1 waiting for sync, 2 running
    int          m_pos;
    int          m_frames;
    bit          m_first;
    logic [31:0] m_count;
    bit          m_err;
    logic [15:0] e_dout;
    bit          e_valid, e_done, e_efirst;
    int          e_chan;

    int          ph;          // bench-side channel phase for aligned syncs
    logic [15:0] len_cur;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_frames = 0; m_first = 0;
        m_count = '0; m_err = 0;
        e_dout = '0; e_valid = 0; e_done = 0; e_efirst = 0; e_chan = 0;
    endtask

    task automatic check_all();
        chk("dout", 64'($unsigned(bus.dout)), 64'(e_dout));
        chk("dout_valid", 64'(bus.dout_valid), 64'(e_valid));
        chk("acc_done", 64'(bus.acc_done), 64'(e_done));
        chk("acc_first", 64'(bus.acc_first), 64'(e_efirst));
        if (e_valid) chk("chan_idx", 64'(bus.chan_idx), 64'(e_chan));
        chk("acc_count", 64'(acc_count), 64'(m_count));
        chk("frame_err", 64'(frame_err), 64'(m_err));
        chk("busy", 64'(busy), 64'(m_mode != 0));
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input bit s_en, input bit s_arm, input logic [15:0] s_len,
                        input bit s_sync, input bit s_valid);
        logic [15:0] d;
        int          lmax;
        bit          restart;
        d = 16'($urandom);
        en = s_en; arm = s_arm; acc_len = s_len;
        bus.sync_in = s_sync; bus.din_valid = s_valid; bus.din = d;
        @(posedge clk);
        #1;
        lmax = (s_len == 0) ? 1 : int'(s_len);
        e_dout = d; e_valid = 0; e_done = 0; e_efirst = 0;
        if (!s_en) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (s_arm) begin
                m_mode = 1; m_err = 0; m_count = '0; m_frames = lmax;
            end
        end else if (s_valid && (m_mode == 2 || s_sync)) begin
            restart = (m_mode == 1) || (s_sync && (m_pos % VL) != 0);
            if (m_mode == 2 && restart) begin
                m_err = 1; m_frames = lmax;
            end
            if (restart) begin
                m_pos = 0; m_first = 1;
            end
            m_mode   = 2;
            e_valid  = 1;
            e_chan   = m_pos % VL;
            e_done   = (m_pos < VL);
            e_efirst = e_done && m_first;
            if (m_pos == 0 && !m_first) m_count = m_count + 32'd1;
            m_pos++;
            if (m_pos == VL * m_frames) begin
                m_pos = 0; m_frames = lmax; m_first = 0;
            end
        end
        check_all();
    endtask

    // Stream with syncs on every channel-0 sample; valid with given percentage.
    task automatic run_aligned(input int n, input int pct);
        bit v;
        for (int k = 0; k < n; k++) begin
            v = ($urandom_range(99) < pct);
            step(1, 0, len_cur, v && (ph % VL == 0), v);
            if (v) ph++;
        end
    endtask

    task automatic start(input logic [15:0] len);
        len_cur = len;
        step(0, 0, len_cur, 0, 0);
        step(1, 1, len_cur, 0, 0);
        ph = 0;
    endtask

    initial begin
        model_reset();
        bus.sync_in = 0; bus.din = '0; bus.din_valid = 0;
        len_cur = 16'd3; ph = 0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Not armed: sync alone does nothing
        step(1, 0, len_cur, 1, 1);
        step(1, 0, len_cur, 1, 1);

        // Basic integration, 3 frames of 4 channels
        start(16'd3);
        run_aligned(40, 100);

        // Misaligned sync at channel 2
        ph = 0;
        start(16'd3);
        run_aligned(14, 100);          // 12 samples completes one integration
        step(1, 0, len_cur, 1, 1);     // arrives at channel 2
        ph = 1;
        run_aligned(14, 100);
        step(1, 1, len_cur, 1, 1);     // arm while running is ignored

        // acc_len = 0 behaves as 1; the new arm clears frame_err
        start(16'd0);
        run_aligned(20, 100);

        // 50 % valid stream
        start(16'd2);
        run_aligned(80, 50);

        // acc_len 3 -> 2 during the first integration
        start(16'd3);
        run_aligned(6, 100);
        len_cur = 16'd2;
        run_aligned(40, 100);

        // arm together with sync in IDLE: the sync is not used
        len_cur = 16'd1;
        step(0, 0, len_cur, 0, 0);
        step(1, 1, len_cur, 1, 1);
        ph = 0;
        run_aligned(12, 100);

        // Unconstrained random traffic
        for (int k = 0; k < 300; k++) begin
            step($urandom_range(99) < 95, $urandom_range(99) < 8,
                 16'($urandom_range(3)), $urandom_range(99) < 30,
                 $urandom_range(99) < 70);
        end

        // Asynchronous reset mid-frame
        start(16'd2);
        run_aligned(6, 100);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        e_dout = '0;
        check_all();
        #10;
        rst_n = 1'b1;
        step(1, 0, len_cur, 1, 1);
        step(1, 0, len_cur, 1, 1);
        start(16'd1);
        run_aligned(10, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
